// File: rtl/iir_pkg.sv
// -----------------------------------------------------------------------------
// iir_pkg
// Definitions shared by the IIR core and its ADC front end.
//   N_BITS      : sample/offset word width (two's complement)
//   FRAC_BITS   : fractional bits of the Q16.16 sample format
//   sample_t    : signed sample word
//   adc_state_t : front-end frame sequencer states
//   sat_sub     : saturating a - b in sample_t
// -----------------------------------------------------------------------------
package iir_pkg;

    localparam int N_BITS    = 32;
    localparam int FRAC_BITS = 16;

    typedef logic signed [N_BITS-1:0] sample_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } adc_state_t;

    // One guard bit is enough for a difference of two N_BITS values. If the
    // guard bit and the top result bit disagree, the true result lies outside
    // the N_BITS range and is clamped in the direction of the guard (sign) bit.
    function automatic sample_t sat_sub(sample_t a, sample_t b);
        logic signed [N_BITS:0] d;
        sample_t                r;
        d = {a[N_BITS-1], a} - {b[N_BITS-1], b};
        if (d[N_BITS] != d[N_BITS-1]) begin
            r = d[N_BITS] ? {1'b1, {(N_BITS-1){1'b0}}} : {1'b0, {(N_BITS-1){1'b1}}};
        end else begin
            r = d[N_BITS-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// -----------------------------------------------------------------------------
// adc_sclk_gen
// Clock divider for the ADC serial clock. While i_run is high it counts CLK_DIV
// clk cycles per half-period; while i_toggle is also high, sclk toggles at the
// end of each half-period. Dropping i_run returns everything to idle (sclk low).
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   i_run        : divider counting enable
//   i_toggle     : allow sclk to toggle at half-period ends
//   o_sclk       : registered serial clock, idle low
//   o_rise       : 1-cycle strobe, sclk goes 0->1 at the end of this cycle
//   o_fall       : 1-cycle strobe, sclk goes 1->0 at the end of this cycle
//   o_tick       : last clk cycle of a half-period (independent of i_toggle)
//   o_half_cnt   : number of sclk toggles since i_run rose
// -----------------------------------------------------------------------------
module adc_sclk_gen #(
    parameter int CLK_DIV = 2,
    parameter int HALF_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_run,
    input  logic              i_toggle,
    output logic              o_sclk,
    output logic              o_rise,
    output logic              o_fall,
    output logic              o_tick,
    output logic [HALF_W-1:0] o_half_cnt
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0]  r_cnt;
    logic              r_sclk;
    logic [HALF_W-1:0] r_half_cnt;
    logic              w_tick;

    assign w_tick = i_run && (r_cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || !i_run) begin
            r_cnt      <= '0;
            r_sclk     <= 1'b0;
            r_half_cnt <= '0;
        end else begin
            if (w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_tick && i_toggle) begin
                r_sclk     <= ~r_sclk;
                r_half_cnt <= r_half_cnt + 1'b1;
            end
        end
    end

    assign o_sclk     = r_sclk;
    assign o_tick     = w_tick;
    assign o_rise     = w_tick && i_toggle && !r_sclk;
    assign o_fall     = w_tick && i_toggle && r_sclk;
    assign o_half_cnt = r_half_cnt;

endmodule

// File: rtl/iir_adc_frontend.sv
// -----------------------------------------------------------------------------
// iir_adc_frontend
// Front end of the IIR filter: a free-running sample timer launches SPI mode 0
// frames to an offset-binary ADC; each received code is converted to signed
// Q16.16, a DC offset is subtracted with saturation, and the result is
// presented on x_o with a one-cycle x_valid_o strobe.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   en_i        : sample timer enable (timer holds at 0 when low)
//   offset_i    : Q16.16 DC offset, sampled in the DONE cycle
//   miso_i      : ADC serial data, sampled as sclk_o rises
//   sclk_o      : ADC serial clock, idle low
//   cs_n_o      : ADC chip select, active low
//   x_o         : latest Q16.16 sample, held between strobes
//   x_valid_o   : 1-cycle pulse when x_o updates
//   busy_o      : a frame is in progress
//   overrun_o   : sticky, a start tick arrived while busy (cleared by reset)
// Handshake: x_valid_o is a pure strobe with no back-pressure; the consumer
// must take x_o in the cycle x_valid_o is high (x_o also stays held after).
// Frame timing: cs_n_o falls, then CLK_DIV setup cycles, FRAME_BITS sclk
// periods, CLK_DIV hold cycles, one DONE cycle, and x_valid_o rises on the
// following edge: CLK_DIV*(2*FRAME_BITS+2)+1 cycles after the cs_n_o fall.
// -----------------------------------------------------------------------------
module iir_adc_frontend
    import iir_pkg::*;
#(
    parameter int ADC_BITS      = 12,
    parameter int FRAME_BITS    = 16,
    parameter int CLK_DIV       = 2,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic [N_BITS-1:0] offset_i,
    input  logic              miso_i,
    output logic              sclk_o,
    output logic              cs_n_o,
    output logic [N_BITS-1:0] x_o,
    output logic              x_valid_o,
    output logic              busy_o,
    output logic              overrun_o
);

    localparam int TMR_W  = $clog2(SAMPLE_PERIOD);
    localparam int HALF_W = $clog2(2 * FRAME_BITS + 1);
    localparam int SHAMT  = FRAC_BITS - (ADC_BITS - 1);

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("CLK_DIV must be >= 1");
    end
    if (FRAME_BITS < ADC_BITS) begin : g_bad_frame_bits
        $error("FRAME_BITS must be >= ADC_BITS");
    end
    if (ADC_BITS - 1 > FRAC_BITS) begin : g_bad_adc_bits
        $error("ADC_BITS-1 must be <= FRAC_BITS");
    end
    if (SAMPLE_PERIOD < 2) begin : g_bad_period
        $error("SAMPLE_PERIOD must be >= 2");
    end

    // ---------------- sample timer ----------------
    logic [TMR_W-1:0] r_timer;
    logic             w_start;

    assign w_start = en_i && (r_timer == TMR_W'(SAMPLE_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset || !en_i) begin
            r_timer <= '0;
        end else if (w_start) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // ---------------- serial clock ----------------
    adc_state_t        r_state;
    logic              w_run;
    logic              w_toggle;
    logic              w_rise;
    logic              w_fall;
    logic              w_div_tick;
    logic [HALF_W-1:0] w_half_cnt;

    // The divider counts through SETUP, SHIFT and HOLD so all three phases are
    // timed from one counter; it only toggles sclk during SHIFT.
    assign w_run    = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);
    assign w_toggle = (r_state == SHIFT);

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV),
        .HALF_W  (HALF_W)
    ) u_sclk_gen (
        .clk        (clk),
        .reset      (reset),
        .i_run      (w_run),
        .i_toggle   (w_toggle),
        .o_sclk     (sclk_o),
        .o_rise     (w_rise),
        .o_fall     (w_fall),
        .o_tick     (w_div_tick),
        .o_half_cnt (w_half_cnt)
    );

    // ---------------- conversion ----------------
    // Only the last ADC_BITS frame bits are kept: the leading filler bits are
    // shifted out of the top of this register before the frame ends.
    logic [ADC_BITS-1:0] r_shift;
    logic [ADC_BITS-1:0] w_s;
    logic [N_BITS-1:0]   w_s_ext;
    sample_t             w_q;
    sample_t             w_x_next;

    // Offset binary to two's complement is an MSB flip.
    assign w_s      = {~r_shift[ADC_BITS-1], r_shift[ADC_BITS-2:0]};
    assign w_s_ext  = {{(N_BITS-ADC_BITS){w_s[ADC_BITS-1]}}, w_s};
    assign w_q      = sample_t'(w_s_ext << SHAMT);
    assign w_x_next = sat_sub(w_q, sample_t'(offset_i));

    // ---------------- frame sequencer ----------------
    logic              r_cs_n;
    logic              r_busy;
    logic [N_BITS-1:0] r_x;
    logic              r_valid;
    logic              r_overrun;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_x       <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_shift   <= '0;
        end else begin
            r_valid <= 1'b0;

            // A tick during SETUP/SHIFT/HOLD is dropped; IDLE and DONE accept it.
            if (w_start && w_run) begin
                r_overrun <= 1'b1;
            end

            if (w_toggle && w_rise) begin
                r_shift <= {r_shift[ADC_BITS-2:0], miso_i};
            end

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= SETUP;
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (w_div_tick) begin
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The last falling edge closes the frame.
                    if (w_fall && (w_half_cnt == HALF_W'(2 * FRAME_BITS - 1))) begin
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_div_tick) begin
                        r_state <= DONE;
                        r_cs_n  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                DONE: begin
                    r_x     <= w_x_next;
                    r_valid <= 1'b1;
                    if (w_start) begin
                        r_state <= SETUP;
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cs_n  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cs_n_o    = r_cs_n;
    assign busy_o    = r_busy;
    assign x_o       = r_x;
    assign x_valid_o = r_valid;
    assign overrun_o = r_overrun;

endmodule

// File: tb/tb_iir_adc_frontend.sv
module tb_iir_adc_frontend;

    localparam int SP1 = 100;
    localparam int SP2 = 50;
    localparam int LAT = 69;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset  = 1'b1;
    logic        en     = 1'b0;
    logic [31:0] offset = '0;
    logic        reset2 = 1'b1;
    logic        en2    = 1'b0;
    logic [31:0] offset2 = '0;

    logic        miso, sclk, cs_n, x_valid, busy, overrun;
    logic [31:0] x;
    logic        miso2, sclk2, cs_n2, x_valid2, busy2, overrun2;
    logic [31:0] x2;

    int n_pass  = 0;
    int n_total = 0;

    iir_adc_frontend #(
        .ADC_BITS(12), .FRAME_BITS(16), .CLK_DIV(2), .SAMPLE_PERIOD(SP1)
    ) dut (
        .clk(clk), .reset(reset), .en_i(en), .offset_i(offset), .miso_i(miso),
        .sclk_o(sclk), .cs_n_o(cs_n), .x_o(x), .x_valid_o(x_valid),
        .busy_o(busy), .overrun_o(overrun)
    );

    iir_adc_frontend #(
        .ADC_BITS(12), .FRAME_BITS(16), .CLK_DIV(2), .SAMPLE_PERIOD(SP2)
    ) dut2 (
        .clk(clk), .reset(reset2), .en_i(en2), .offset_i(offset2), .miso_i(miso2),
        .sclk_o(sclk2), .cs_n_o(cs_n2), .x_o(x2), .x_valid_o(x_valid2),
        .busy_o(busy2), .overrun_o(overrun2)
    );

    // ---------------- SPI mode 0 ADC models ----------------
    // The ADC presents the frame MSB first: bit 15 when cs_n falls, then the
    // next bit after every sclk falling edge.
    logic [15:0] frame1 = '0;
    logic [15:0] frame2 = '0;
    int idx1 = 0;
    int idx2 = 0;

    always @(negedge cs_n) idx1 = 0;
    always @(negedge sclk) if (!cs_n) idx1 = idx1 + 1;
    always @(negedge cs_n2) idx2 = 0;
    always @(negedge sclk2) if (!cs_n2) idx2 = idx2 + 1;

    assign miso  = (idx1 < 16) ? frame1[15 - idx1] : 1'b0;
    assign miso2 = (idx2 < 16) ? frame2[15 - idx2] : 1'b0;

    // ---------------- driver / wait tasks ----------------
    task automatic wait_cs_low(input bit sel, input int max_cyc, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < max_cyc) begin
            @(negedge clk);
            n++;
            if ((sel ? cs_n2 : cs_n) == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cs_high(input bit sel, input int max_cyc, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < max_cyc) begin
            @(negedge clk);
            n++;
            if ((sel ? cs_n2 : cs_n) == 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid(input bit sel, input int max_cyc, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < max_cyc) begin
            @(negedge clk);
            n++;
            if ((sel ? x_valid2 : x_valid) == 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Loads the ADC model and offset between frames, then waits for the next
    // frame on dut and returns x_o, the cs_n fall -> x_valid latency, and busy
    // as seen right after cs_n fell.
    task automatic run_frame(input logic [3:0] lead, input logic [11:0] code,
                             input logic [31:0] off, output logic [31:0] xv,
                             output int lat, output logic busy_at_start, output bit ok);
        bit ok1, ok2, ok3;
        int n;
        wait_cs_high(1'b0, 200, ok1);
        frame1 = {lead, code};
        offset = off;
        wait_cs_low(1'b0, 250, n, ok2);
        busy_at_start = busy;
        wait_valid(1'b0, 100, lat, ok3);
        xv = x;
        ok = ok1 && ok2 && ok3;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset  = 1'b1;
        reset2 = 1'b1;
        en     = 1'b0;
        en2    = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (cs_n !== 1'b1) $display("FAIL reset_cs_n: got %b want 1", cs_n); else n_pass++;
        n_total++; if (sclk !== 1'b0) $display("FAIL reset_sclk: got %b want 0", sclk); else n_pass++;
        n_total++; if (x !== 32'h0) $display("FAIL reset_x: got %h want 00000000", x); else n_pass++;
        n_total++; if (x_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", x_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else n_pass++;
        reset  = 1'b0;
        reset2 = 1'b0;
        en     = 1'b1;
    endtask

    task automatic test_midscale;
        logic [31:0] xv;
        int          lat;
        logic        b0;
        bit          ok;
        run_frame(4'h0, 12'h800, 32'h0, xv, lat, b0, ok);
        n_total++; if (!ok || lat != LAT) $display("FAIL latency: got %0d (ok=%0b) want %0d", lat, ok, LAT); else n_pass++;
        n_total++; if (xv !== 32'h0) $display("FAIL midscale_x: got %h want 00000000", xv); else n_pass++;
        n_total++; if (b0 !== 1'b1) $display("FAIL busy_in_frame: got %b want 1", b0); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL busy_at_valid: got %b want 0", busy); else n_pass++;
        @(negedge clk);
        n_total++; if (x_valid !== 1'b0) $display("FAIL valid_pulse_width: got %b want 0", x_valid); else n_pass++;
        n_total++; if (x !== 32'h0) $display("FAIL x_held: got %h want 00000000", x); else n_pass++;
    endtask

    task automatic test_codes;
        logic [3:0]  leads [4];
        logic [11:0] codes [4];
        logic [31:0] exps  [4];
        logic [31:0] xv;
        int          lat;
        logic        b0;
        bit          ok;
        leads[0] = 4'h0; codes[0] = 12'hFFF; exps[0] = 32'h0000FFE0;
        leads[1] = 4'h0; codes[1] = 12'h000; exps[1] = 32'hFFFF0000;
        leads[2] = 4'hF; codes[2] = 12'h800; exps[2] = 32'h00000000;
        leads[3] = 4'hF; codes[3] = 12'hA00; exps[3] = 32'h00004000;
        for (int i = 0; i < 4; i++) begin
            run_frame(leads[i], codes[i], 32'h0, xv, lat, b0, ok);
            n_total++;
            if (!ok || xv !== exps[i])
                $display("FAIL code_%h_lead_%h: got %h (ok=%0b) want %h", codes[i], leads[i], xv, ok, exps[i]);
            else
                n_pass++;
        end
    endtask

    task automatic test_saturation;
        logic [11:0] codes [4];
        logic [31:0] offs  [4];
        logic [31:0] exps  [4];
        logic [31:0] xv;
        int          lat;
        logic        b0;
        bit          ok;
        codes[0] = 12'h000; offs[0] = 32'h7FFFFFFF; exps[0] = 32'h80000000;
        codes[1] = 12'hFFF; offs[1] = 32'h80000000; exps[1] = 32'h7FFFFFFF;
        codes[2] = 12'h800; offs[2] = 32'h00010000; exps[2] = 32'hFFFF0000;
        codes[3] = 12'hFFF; offs[3] = 32'hFFFF0000; exps[3] = 32'h0001FFE0;
        for (int i = 0; i < 4; i++) begin
            run_frame(4'h0, codes[i], offs[i], xv, lat, b0, ok);
            n_total++;
            if (!ok || xv !== exps[i])
                $display("FAIL offset_%h_code_%h: got %h (ok=%0b) want %h", offs[i], codes[i], xv, ok, exps[i]);
            else
                n_pass++;
        end
        offset = 32'h0;
    endtask

    task automatic test_reset_mid_frame;
        int   rises;
        int   n;
        int   valids;
        logic prev;
        bit   ok;
        logic [31:0] xv;
        int          lat;
        logic        b0;
        wait_cs_high(1'b0, 200, ok);
        frame1 = {4'h0, 12'h123};
        wait_cs_low(1'b0, 250, n, ok);
        rises = 0;
        prev  = sclk;
        n     = 0;
        while (rises < 8 && n < 100) begin
            @(negedge clk);
            n++;
            if (sclk && !prev) rises++;
            prev = sclk;
        end
        n_total++; if (rises != 8) $display("FAIL mid_reset_edges: got %0d sclk rises want 8", rises); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_total++; if (cs_n !== 1'b1) $display("FAIL mid_reset_cs_n: got %b want 1", cs_n); else n_pass++;
        n_total++; if (sclk !== 1'b0) $display("FAIL mid_reset_sclk: got %b want 0", sclk); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b want 0", busy); else n_pass++;
        reset  = 1'b0;
        valids = 0;
        if (x_valid) valids++;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (x_valid) valids++;
        end
        n_total++; if (valids != 0) $display("FAIL mid_reset_no_valid: got %0d pulses want 0", valids); else n_pass++;
        run_frame(4'h0, 12'h123, 32'h0, xv, lat, b0, ok);
        n_total++; if (!ok || xv !== 32'hFFFF2460) $display("FAIL after_reset_x: got %h (ok=%0b) want FFFF2460", xv, ok); else n_pass++;
    endtask

    task automatic test_enable;
        int n;
        int lows;
        bit ok;
        wait_cs_high(1'b0, 200, ok);
        frame1 = {4'h0, 12'hFFF};
        wait_cs_low(1'b0, 250, n, ok);
        repeat (20) @(negedge clk);
        en = 1'b0;
        wait_valid(1'b0, 100, n, ok);
        n_total++; if (!ok || x !== 32'h0000FFE0) $display("FAIL en_drop_frame: got %h (ok=%0b) want 0000FFE0", x, ok); else n_pass++;
        lows = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (!cs_n) lows++;
        end
        n_total++; if (lows != 0) $display("FAIL en_low_quiet: got %0d cs_n low cycles want 0", lows); else n_pass++;
        frame1 = {4'h0, 12'h000};
        en = 1'b1;
        wait_cs_low(1'b0, 250, n, ok);
        n_total++; if (!ok || n != SP1) $display("FAIL timer_restart: got %0d cycles (ok=%0b) want %0d", n, ok, SP1); else n_pass++;
        wait_valid(1'b0, 100, n, ok);
        n_total++; if (!ok || x !== 32'hFFFF0000) $display("FAIL en_resume_x: got %h (ok=%0b) want FFFF0000", x, ok); else n_pass++;
    endtask

    task automatic test_overrun;
        logic [11:0] codes [3];
        logic [31:0] exps  [3];
        int n;
        bit ok;
        codes[0] = 12'hA00; exps[0] = 32'h00004000;
        codes[1] = 12'h400; exps[1] = 32'hFFFF8000;
        codes[2] = 12'h801; exps[2] = 32'h00000020;
        frame2  = {4'h0, codes[0]};
        offset2 = 32'h0;
        en2     = 1'b1;
        wait_cs_low(1'b1, 60, n, ok);
        n_total++; if (!ok || n != SP2) $display("FAIL ovr_first_tick: got %0d cycles (ok=%0b) want %0d", n, ok, SP2); else n_pass++;
        n_total++; if (overrun2 !== 1'b0) $display("FAIL ovr_before_2nd_tick: got %b want 0", overrun2); else n_pass++;
        repeat (52) @(negedge clk);
        n_total++; if (overrun2 !== 1'b1) $display("FAIL ovr_after_2nd_tick: got %b want 1", overrun2); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) wait_cs_low(1'b1, 60, n, ok);
            wait_valid(1'b1, 100, n, ok);
            n_total++;
            if (!ok || x2 !== exps[i])
                $display("FAIL ovr_frame_%0d: got %h (ok=%0b) want %h", i, x2, ok, exps[i]);
            else
                n_pass++;
            if (i < 2) frame2 = {4'h0, codes[i+1]};
        end
        n_total++; if (overrun2 !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun2); else n_pass++;
        en2 = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset;
        test_midscale;
        test_codes;
        test_saturation;
        test_reset_mid_frame;
        test_enable;
        test_overrun;
        n_total++; if (overrun !== 1'b0) $display("FAIL no_overrun_nominal: got %b want 0", overrun); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
